// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if
// Request/result bundle between decode/EX and the HI/LO mul/div unit.
//   master : drives start_i, op_i, src1_i, src2_i, flush_i; receives results
//   slave  : the mul/div unit
// Signals:
//   start_i        request (sampled only while the unit is idle)
//   op_i           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1_i/src2_i  rs / rt operands
//   flush_i        cancel any in-flight operation
//   stall_o        pipeline stall request
//   busy_o         unit not idle
//   hi_we_o/lo_we_o one-cycle HI/LO write strobes
//   hi_o/lo_o      HI/LO write data
//   hilo_fwd_bus_o {hi_we_o, lo_we_o, hi_o, lo_o} for bypass readers
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     src1_i;
    logic [WIDTH-1:0]     src2_i;
    logic                 flush_i;
    logic                 stall_o;
    logic                 busy_o;
    logic                 hi_we_o;
    logic                 lo_we_o;
    logic [WIDTH-1:0]     hi_o;
    logic [WIDTH-1:0]     lo_o;
    logic [2*WIDTH+1:0]   hilo_fwd_bus_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, flush_i,
        input  stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o, hilo_fwd_bus_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, flush_i,
        output stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o, hilo_fwd_bus_o
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative multiply/divide engine of the EX stage and writer of HI/LO.
// MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring radix-2
// divider; both take WIDTH iterations, then one DONE cycle issues the
// HI/LO write strobes and the matching forwarding bus.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     hilo_muldiv_unit_if.slave (request, flush, stall, results)
// Build option:
//   HILO_FAST_MUL_EN  when defined, MULT/MULTU are computed with a single
//                     combinational multiply and go IDLE -> DONE directly.
//
// state | meaning
// IDLE  | waiting for start_i
// MUL   | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring divide iterations, one quotient bit per cycle
// DONE  | HI/LO write strobes asserted for this one cycle
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    hilo_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    // MUL: {partial product high, multiplier shifting out}
    // DIV: {remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     dsr, dsr_nxt;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     src1_raw, src1_raw_nxt;
    logic                 is_div, is_div_nxt;
    logic                 neg_q, neg_q_nxt;     // product / quotient negative
    logic                 neg_r, neg_r_nxt;     // remainder negative
    logic                 div_zero, div_zero_nxt;

    logic                 accept;
    logic                 op_signed;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_diff;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     res_hi, res_lo;
    logic                 wr;

    assign accept    = (state == S_IDLE) && bus.start_i && !bus.flush_i;
    assign op_signed = ~bus.op_i[0];
    assign abs1      = (op_signed && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
    assign abs2      = (op_signed && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : '0);
    // Trial subtract with one extra bit so the borrow lands in the MSB.
    assign div_diff  = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, dsr};
    assign last_iter = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            dsr      <= '0;
            src1_raw <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            dsr      <= dsr_nxt;
            src1_raw <= src1_raw_nxt;
            is_div   <= is_div_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            div_zero <= div_zero_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        dsr_nxt      = dsr;
        src1_raw_nxt = src1_raw;
        is_div_nxt   = is_div;
        neg_q_nxt    = neg_q;
        neg_r_nxt    = neg_r;
        div_zero_nxt = div_zero;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt      = '0;
                    src1_raw_nxt = bus.src1_i;
                    is_div_nxt   = bus.op_i[1];
                    neg_q_nxt    = op_signed && (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
                    neg_r_nxt    = op_signed && bus.src1_i[WIDTH-1];
                    div_zero_nxt = (bus.src2_i == '0);
                    if (bus.op_i[1]) begin
                        dsr_nxt   = abs2;
                        acc_nxt   = {{WIDTH{1'b0}}, abs1};
                        state_nxt = S_DIV;
                    end else begin
                        dsr_nxt   = abs1;
`ifdef HILO_FAST_MUL_EN
                        acc_nxt   = {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
                        state_nxt = S_DONE;
`else
                        acc_nxt   = {{WIDTH{1'b0}}, abs2};
                        state_nxt = S_MUL;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_nxt = {mul_sum, acc[WIDTH-1:1]};
                if (last_iter) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DIV: begin
                // Borrow set: restore (keep shifted remainder), quotient bit 0.
                if (div_diff[WIDTH+1]) begin
                    acc_nxt = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1], acc[WIDTH-2:0], 1'b0};
                end else begin
                    acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end
                if (last_iter) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (bus.flush_i && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    assign mul_res = neg_q ? -acc : acc;

    always_comb begin
        res_hi = mul_res[2*WIDTH-1:WIDTH];
        res_lo = mul_res[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                // No trap on divide by zero: all-ones quotient, raw dividend.
                res_lo = '1;
                res_hi = src1_raw;
            end else begin
                res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign wr                 = (state == S_DONE) && !bus.flush_i;
    assign bus.hi_we_o        = wr;
    assign bus.lo_we_o        = wr;
    assign bus.hi_o           = wr ? res_hi : '0;
    assign bus.lo_o           = wr ? res_lo : '0;
    assign bus.hilo_fwd_bus_o = {bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o};
    assign bus.busy_o         = (state != S_IDLE);
    // Low in DONE so the stalled instruction advances as the write lands.
    assign bus.stall_o        = accept || (state == S_MUL) || (state == S_DIV);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    hilo_muldiv_unit_if bus();

    hilo_muldiv_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: an accepted op is "active" from the accepting edge
    // until its write cycle (phase == latency) has passed.
    bit          m_active = 0;
    int          m_start  = 0;
    int          m_lat    = 0;
    logic [31:0] m_hi, m_lo;
    int          m_ph;
    bit          m_idle;

    logic [31:0] got_hi, got_lo;
    int          n_writes = 0;
    int          w_cyc    = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {hi, lo} as defined by the ISA rules, in plain arithmetic.
    function automatic logic [63:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        int          q, r;
        case (op)
            2'b00: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                return ps;
            end
            2'b01: begin
                pu = {32'b0, a} * {32'b0, b};
                return pu;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 0;
        end else begin
            m_ph   = cyc - m_start;
            m_idle = !m_active;
            if (m_active && (bus.flush_i || m_ph >= m_lat)) m_active = 0;
            cyc++;
            if (m_idle && bus.start_i && !bus.flush_i) begin
                m_active = 1;
                m_start  = cyc;
                m_lat    = bus.op_i[1] ? DIV_LAT : MUL_LAT;
                {m_hi, m_lo} = ref_result(bus.op_i, bus.src1_i, bus.src2_i);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    logic        e_busy, e_stall, e_we;
    logic [31:0] e_hi, e_lo;
    int          ph;
    always @(negedge clk) begin
        if (!resetn) begin
            check("reset_outs", {bus.busy_o, bus.stall_o, bus.hi_we_o, bus.lo_we_o,
                                 bus.hi_o, bus.lo_o, bus.hilo_fwd_bus_o}, '0);
        end else begin
            ph      = cyc - m_start;
            e_busy  = m_active && (ph <= m_lat);
            e_we    = m_active && (ph == m_lat) && !bus.flush_i;
            e_stall = (m_active && ph < m_lat) || (!m_active && bus.start_i && !bus.flush_i);
            e_hi    = e_we ? m_hi : 32'd0;
            e_lo    = e_we ? m_lo : 32'd0;
            check("outs", {bus.busy_o, bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o},
                          {e_busy, e_stall, e_we, e_we, e_hi, e_lo});
            check("fwd_bus", bus.hilo_fwd_bus_o, {e_we, e_we, e_hi, e_lo});
            if (bus.hi_we_o) begin
                n_writes++;
                got_hi = bus.hi_o;
                got_lo = bus.lo_o;
                w_cyc  = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", m_active, 0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
    endtask

    task automatic run_op(string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int nw, t0;
        nw = n_writes;
        issue(op, a, b);
        t0 = m_start;
        wait_idle();
        check({name, "_writes"}, n_writes - nw, 1);
        check({name, "_result"}, {got_hi, got_lo}, exp);
        check({name, "_latency"}, w_cyc - t0, lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    int          nw;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int          k;

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.flush_i = 1'b0;

        // Pin the reference model to hand-computed values.
        check("pin_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("pin_mult",  ref_result(2'b00, -32'sd7, 32'd3), 64'hFFFF_FFFF_FFFF_FFEB);
        check("pin_div",   ref_result(2'b10, -32'sd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_divu",  ref_result(2'b11, 32'd100, 32'd7), {32'd2, 32'd14});

        repeat (3) tick();
        check("reset_state", {bus.busy_o, bus.stall_o, bus.hilo_fwd_bus_o}, '0);
        #2 resetn = 1'b1;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT);
        run_op("mult_neg",  2'b00, -32'sd7, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
        run_op("div_neg",   2'b10, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
        run_op("divu",      2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT);
        run_op("divu_zero", 2'b11, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, DIV_LAT);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_LAT);
        run_op("multu_6x7", 2'b01, 32'd6, 32'd7, {32'd0, 32'd42}, MUL_LAT);

        // Flush mid-divide: no write, idle next cycle, next op unaffected.
        nw = n_writes;
        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_busy", bus.busy_o, 1'b0);
        repeat (40) tick();
        check("flush_no_write", n_writes - nw, 0);
        run_op("after_flush", 2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, MUL_LAT);

        // start together with flush in IDLE is ignored
        bus.op_i = 2'b11; bus.src1_i = 32'd9; bus.src2_i = 32'd2;
        bus.start_i = 1'b1; bus.flush_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        check("start_flush_ignored", bus.busy_o, 1'b0);

        // Asynchronous reset between clock edges mid-divide.
        nw = n_writes;
        issue(2'b10, 32'd77, 32'd5);
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        check("async_reset_outs", {bus.busy_o, bus.stall_o, bus.hilo_fwd_bus_o}, '0);
        tick();
        #2 resetn = 1'b1;
        repeat (40) tick();
        check("reset_no_write", n_writes - nw, 0);

        // Randomized traffic with protocol-error starts and random flushes.
        for (int i = 0; i < 80; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick();
            r_b  = pick();
            wait_idle();
            bus.op_i    = r_op;
            bus.src1_i  = r_a;
            bus.src2_i  = r_b;
            bus.start_i = 1'b1;
            bus.flush_i = ($urandom_range(0, 9) == 0);
            tick();
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
            k = $urandom_range(0, 40);
            for (int j = 0; j < k && m_active; j++) begin
                bus.start_i = ($urandom_range(0, 7) == 0);
                bus.op_i    = 2'($urandom_range(0, 3));
                bus.src1_i  = $urandom;
                bus.src2_i  = $urandom;
                bus.flush_i = ($urandom_range(0, 40) == 0);
                tick();
            end
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
            wait_idle();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide engine in the EX stage. It is the writer side of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from decode and stalls the pipeline while computing.
- On completion, issues a one-cycle HI/LO write plus a matching 66-bit forwarding bus {hi_we, lo_we, hi[31:0], lo[31:0]} for the HI/LO bypass readers.

Parameters:
- WIDTH, 32, operand width; HI/LO width; iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start_i  input  1  request; sampled only in IDLE
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src1_i  input  32  rs: multiplicand / dividend
- src2_i  input  32  rt: multiplier / divisor
- flush_i  input  1  cancel in-flight op (exception/branch flush)
- stall_o  output  1  pipeline stall request
- busy_o  output  1  state != IDLE
- hi_we_o  output  1  HI write strobe, one cycle
- lo_we_o  output  1  LO write strobe, one cycle
- hi_o  output  32  HI write data
- lo_o  output  32  LO write data
- hilo_fwd_bus_o  output  66  {hi_we_o, lo_we_o, hi_o, lo_o}

Behaviour:
- Reset (resetn=0, async): state=IDLE, counter=0, all datapath regs 0, all outputs 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i=1 and flush_i=0: latch operands and op; go to MUL (op[1]=0) or DIV (op[1]=1); counter=0.
  - Signed ops (op[0]=0) latch |src1|, |src2| and record result signs.
- MUL: unsigned shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring radix-2, one quotient bit per cycle.
  - Each cycle: 33-bit trial subtract of divisor from {rem, next dividend bit}.
- MUL/DIV → DONE when counter reaches WIDTH-1, i.e. after exactly WIDTH=32 cycles in the state.
- DONE: hi_we_o=lo_we_o=1 for exactly one cycle; hi_o/lo_o valid; next state IDLE.
- Latency: start accepted at edge T; write strobes high during cycle T+33; unit accepts the next start at T+34.
- stall_o:
  - Combinational: (IDLE && start_i && !flush_i) || MUL || DIV.
  - Low in DONE, so the stalled instruction advances the same cycle the write is visible.
- Strobes and hi_o/lo_o are 0 in every state except DONE.
- Mult results: HI:LO = 64-bit product; signed result is negated when sign(src1) != sign(src2).
- Div results: LO=quotient, HI=remainder.
  - Signed quotient is negated when signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero: no trap. LO=32'hFFFFFFFF, HI=src1 (raw dividend); takes the full 33-cycle latency.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- flush_i in MUL, DIV or DONE: next state IDLE; no write strobe issued (DONE strobes forced 0 that cycle); counter cleared.
- flush_i with start_i in IDLE: start ignored.
- start_i outside IDLE: ignored (decode is stalled, so this is a protocol error; the unit must not restart).
- Reset mid-operation: immediate return to IDLE; no write.

Optional Feature:
- Macro: HILO_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational 64-bit multiply.
  - Path is IDLE → DONE directly; start at edge T, strobes during cycle T+1.
  - stall_o is high only in the accepting cycle.
  - Division is unchanged.
- Undefined: multiply is iterative with the 33-cycle latency above.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; strobes exactly at cycle T+33; stall_o high T..T+32.
- MULT -7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; hilo_fwd_bus_o={1,1,HI,LO} in the DONE cycle and 0 otherwise.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100 / 7 → LO=14, HI=2.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV started, flush_i pulsed at cycle T+10 → state IDLE next cycle; no strobe ever; a new MULTU 3×5 issued right after yields HI=0, LO=15.
- resetn dropped asynchronously mid-DIV (not on a clock edge) → all outputs 0 immediately; no strobe after release. With HILO_FAST_MUL_EN: MULTU 6×7 → LO=42 at T+1.
